// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - fetch sequencer bus: imem handshake and datapath signals
//
// master : the sequencer (drives imem_req/addr, instr, status)
// slave  : instruction memory plus datapath (drives start, ack, rdata, branch_taken)
interface fetch_sequencer_if;
  logic        start;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        branch_taken;
  logic [63:0] pc;
  logic        halted;
  logic        timeout_err;
  logic [31:0] retired_cnt;

  modport master (
    input  start, imem_ack, imem_rdata, branch_taken,
    output imem_req, imem_addr, instr, instr_valid, pc, halted, timeout_err, retired_cnt
  );

  modport slave (
    output start, imem_ack, imem_rdata, branch_taken,
    input  imem_req, imem_addr, instr, instr_valid, pc, halted, timeout_err, retired_cnt
  );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and instruction fetch sequencer for the single-cycle RV64 datapath
//
// Ports:
//   clk   : clock, all state on rising edge
//   rst   : synchronous active-high reset
//   bus   : fetch_sequencer_if.master
//           start in, imem_req/imem_addr out, imem_ack/imem_rdata in,
//           instr/instr_valid out, branch_taken in, pc/halted/timeout_err/retired_cnt out
// Parameters:
//   RESET_PC      : PC loaded on reset
//   FETCH_TIMEOUT : REQ cycles without ack before giving up (FETCH_TIMEOUT_EN builds only)
// Optional feature macro: FETCH_TIMEOUT_EN (fetch timeout counter and timeout_err flag)
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC      = 64'h0,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master bus
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] retired_q, retired_d;
  logic        req_q, req_d;
  logic        terr_q, terr_d;
  logic [63:0] br_imm;
  logic [63:0] br_target;

  // B-type immediate, sign-extended from instr[31]
  assign br_imm    = {{52{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign br_target = pc_q + br_imm;

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(FETCH_TIMEOUT + 1);
  logic [TW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    terr_d    = terr_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = REQ;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      REQ: begin
        // ack has priority over a timeout reached in the same cycle
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          state_d = EXEC;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == TW'(FETCH_TIMEOUT - 1)) begin
          state_d = HALT;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
`endif
      end
      EXEC: begin
        retired_d = retired_q + 32'd1;
        if (ir_q[6:0] == OP_SYSTEM) begin
          state_d = HALT;
        end else if (ir_q[6:0] == OP_BRANCH && bus.branch_taken) begin
          // a misaligned target stops the core with pc still on the branch
          if (br_target[1:0] != 2'b00) begin
            state_d = HALT;
          end else begin
            pc_d    = br_target;
            state_d = REQ;
          end
        end else begin
          pc_d    = pc_q + 64'd4;
          state_d = REQ;
        end
`ifdef FETCH_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = IDLE;
    endcase
    // request is registered so it is stable for the whole REQ stay
    req_d = (state_d == REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= NOP;
      retired_q <= 32'd0;
      req_q     <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      req_q     <= req_d;
      terr_q    <= terr_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
  assign bus.timeout_err = terr_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr       = (state_q == EXEC) ? ir_q : NOP;
  assign bus.instr_valid = (state_q == EXEC);
  assign bus.halted      = (state_q == HALT);
  assign bus.retired_cnt = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ADDI  = 32'h0050_0093;
  localparam logic [31:0] BEQM4 = 32'hFE00_0EE3;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] BEQP2 = 32'h0000_0163;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [63:0] exp_q[$];

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(64'h0), .FETCH_TIMEOUT(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.branch_taken = 1'b0;
    exp_q.delete();
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic expect_req(output logic [63:0] exp, output bit ok);
    ok = 1'b0;
    exp = 64'h0;
    for (int i = 0; i < 50; i++) begin
      if (bus.imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL req_wait: imem_req=%b want 1 within 50 cycles", bus.imem_req);
      return;
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      ok = 1'b0;
      $display("FAIL scoreboard_empty: request at %h with no expected address", bus.imem_addr);
      return;
    end
    exp = exp_q.pop_front();
    total++;
    if (bus.imem_addr !== exp) begin
      bad++;
      $display("FAIL req_addr: got %h want %h", bus.imem_addr, exp);
    end
  endtask

  task automatic fetch_one(input logic [31:0] data, input bit taken, input int waits);
    logic [63:0] exp;
    bit ok;
    expect_req(exp, ok);
    if (!ok) return;
    for (int w = 0; w < waits; w++) begin
      step();
      total++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp) begin
        bad++;
        $display("FAIL wait_stable: req=%b addr=%h want req=1 addr=%h", bus.imem_req, bus.imem_addr, exp);
      end
    end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = data;
    step();
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    bus.branch_taken = taken;
    total++;
    if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
      bad++;
      $display("FAIL exec_valid: valid=%b req=%b want 1/0", bus.instr_valid, bus.imem_req);
    end
    total++;
    if (bus.instr !== data) begin
      bad++;
      $display("FAIL exec_instr: got %h want %h", bus.instr, data);
    end
    step();
    bus.branch_taken = 1'b0;
    total++;
    if (bus.instr_valid !== 1'b0 || bus.instr !== NOP) begin
      bad++;
      $display("FAIL post_exec: valid=%b instr=%h want 0/%h", bus.instr_valid, bus.instr, NOP);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    bus.branch_taken = 1'b1;
    step();
    total++;
    if (bus.imem_req !== 1'b0 || bus.pc !== 64'h0 || bus.imem_addr !== 64'h0) begin
      bad++;
      $display("FAIL reset_req_pc: req=%b pc=%h want 0/0", bus.imem_req, bus.pc);
    end
    total++;
    if (bus.instr !== NOP || bus.instr_valid !== 1'b0 || bus.halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_instr: instr=%h valid=%b halted=%b", bus.instr, bus.instr_valid, bus.halted);
    end
    total++;
    if (bus.timeout_err !== 1'b0 || bus.retired_cnt !== 32'd0) begin
      bad++;
      $display("FAIL reset_status: terr=%b retired=%0d want 0/0", bus.timeout_err, bus.retired_cnt);
    end
    do_reset();
  endtask

  task automatic test_sequential();
    do_reset();
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    exp_q.push_back(64'h8);
    total++;
    if (bus.imem_req !== 1'b0) begin
      bad++;
      $display("FAIL idle_req: got %b want 0", bus.imem_req);
    end
    pulse_start();
    total++;
    if (bus.imem_req !== 1'b1) begin
      bad++;
      $display("FAIL start_req: got %b want 1", bus.imem_req);
    end
    for (int i = 0; i < 3; i++) fetch_one(ADDI, 1'b0, 0);
    total++;
    if (bus.retired_cnt !== 32'd3) begin
      bad++;
      $display("FAIL seq_retired: got %0d want 3", bus.retired_cnt);
    end
  endtask

  task automatic test_branch();
    logic [63:0] exp;
    bit ok;
    do_reset();
    foreach (exp_q[i]) exp_q.delete();
    exp_q.push_back(64'h00);
    exp_q.push_back(64'h04);
    exp_q.push_back(64'h08);
    exp_q.push_back(64'h0C);
    exp_q.push_back(64'h10);
    exp_q.push_back(64'h0C);
    exp_q.push_back(64'h10);
    exp_q.push_back(64'h14);
    pulse_start();
    for (int i = 0; i < 4; i++) fetch_one(ADDI, 1'b0, 0);
    fetch_one(BEQM4, 1'b1, 0);
    fetch_one(ADDI, 1'b0, 0);
    fetch_one(BEQM4, 1'b0, 0);
    expect_req(exp, ok);
  endtask

  task automatic test_halt();
    do_reset();
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    exp_q.push_back(64'h8);
    pulse_start();
    fetch_one(ADDI, 1'b0, 0);
    fetch_one(ADDI, 1'b0, 0);
    fetch_one(ECALL, 1'b0, 0);
    total++;
    if (bus.halted !== 1'b1 || bus.pc !== 64'h8 || bus.imem_req !== 1'b0) begin
      bad++;
      $display("FAIL halt_entry: halted=%b pc=%h req=%b want 1/8/0", bus.halted, bus.pc, bus.imem_req);
    end
    bus.imem_ack = 1'b1;
    pulse_start();
    step();
    pulse_start();
    bus.imem_ack = 1'b0;
    total++;
    if (bus.halted !== 1'b1 || bus.pc !== 64'h8 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL halt_hold: halted=%b pc=%h req=%b valid=%b", bus.halted, bus.pc, bus.imem_req, bus.instr_valid);
    end
    total++;
    if (bus.retired_cnt !== 32'd3) begin
      bad++;
      $display("FAIL halt_retired: got %0d want 3", bus.retired_cnt);
    end
  endtask

  task automatic test_wait_and_reset();
    do_reset();
    exp_q.push_back(64'h0);
    pulse_start();
    fetch_one(ADDI, 1'b0, 5);
    total++;
    if (bus.retired_cnt !== 32'd1 || bus.imem_addr !== 64'h4) begin
      bad++;
      $display("FAIL wait_retire: retired=%0d addr=%h want 1/4", bus.retired_cnt, bus.imem_addr);
    end
    step();
    step();
    rst = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = ADDI;
    step();
    rst = 1'b0;
    bus.imem_ack = 1'b0;
    total++;
    if (bus.imem_req !== 1'b0 || bus.pc !== 64'h0 || bus.retired_cnt !== 32'd0 || bus.instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL midfetch_reset: req=%b pc=%h retired=%0d valid=%b", bus.imem_req, bus.pc, bus.retired_cnt, bus.instr_valid);
    end
    step();
    step();
    total++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: req=%b valid=%b want 0/0", bus.imem_req, bus.instr_valid);
    end
    exp_q.push_back(64'h0);
    pulse_start();
    fetch_one(ADDI, 1'b0, 0);
  endtask

  task automatic test_misaligned();
    do_reset();
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    pulse_start();
    fetch_one(ADDI, 1'b0, 0);
    fetch_one(BEQP2, 1'b1, 0);
    total++;
    if (bus.halted !== 1'b1 || bus.pc !== 64'h4 || bus.imem_req !== 1'b0) begin
      bad++;
      $display("FAIL misaligned: halted=%b pc=%h req=%b want 1/4/0", bus.halted, bus.pc, bus.imem_req);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    pulse_start();
`ifdef FETCH_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.halted === 1'b1) break;
      if (bus.imem_req === 1'b1) n++;
      step();
    end
    total++;
    if (n != 16 || bus.halted !== 1'b1 || bus.timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_halt: req_cycles=%0d halted=%b terr=%b want 16/1/1", n, bus.halted, bus.timeout_err);
    end
    total++;
    if (bus.imem_req !== 1'b0 || bus.pc !== 64'h0) begin
      bad++;
      $display("FAIL timeout_state: req=%b pc=%h want 0/0", bus.imem_req, bus.pc);
    end
    do_reset();
    exp_q.push_back(64'h0);
    pulse_start();
    fetch_one(ADDI, 1'b0, 15);
    total++;
    if (bus.timeout_err !== 1'b0 || bus.halted !== 1'b0 || bus.retired_cnt !== 32'd1) begin
      bad++;
      $display("FAIL timeout_ack_wins: terr=%b halted=%b retired=%0d want 0/0/1", bus.timeout_err, bus.halted, bus.retired_cnt);
    end
`else
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.imem_req === 1'b1) n++;
      step();
    end
    total++;
    if (n != 40 || bus.imem_req !== 1'b1 || bus.halted !== 1'b0 || bus.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL no_timeout: req_cycles=%0d req=%b halted=%b terr=%b want 40/1/0/0", n, bus.imem_req, bus.halted, bus.timeout_err);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.branch_taken = 1'b0;
    step();
    test_reset();
    test_sequential();
    test_branch();
    test_halt();
    test_wait_and_reset();
    test_misaligned();
    test_timeout();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
